seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter that drives a serial sequence detector (e.g. the 1101 Mealy detectors) from the stimulus side.
- Loads a parallel PAT_W-bit pattern and emits it MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, then signals completion.
- Used in self-checking loops and as a bit-stream source for the FSM collection.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 4, width of repeat count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_W  pattern to send, bit PAT_W-1 first.
- repeat_n  input  CNT_W  number of pattern repetitions; 0 is legal.
- x_out  output  1  serial bit, registered.
- x_valid  output  1  high when x_out carries a pattern bit.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse at end of job.

Behaviour:
- Reset: synchronous, active-high, single clock domain.
  - At the edge where rst=1: state=IDLE; x_out=0, x_valid=0, busy=0, done=0; shift register and counters cleared.
  - rst overrides everything, including mid-transmission. The partial stream is abandoned with no done pulse.
- States:
  - IDLE: outputs 0. If start=1 at edge T:
    - Capture pattern and repeat_n.
    - If repeat_n!=0, go to SHIFT. In cycle T+1: x_out=pattern[PAT_W-1], x_valid=1, busy=1.
    - If repeat_n==0, go to DONE directly. done=1 in cycle T+1, with no valid bits.
  - SHIFT: each edge shifts out the next bit and decrements the bit counter (PAT_W-1 down to 0).
    - After the last bit of a repetition, decrement the remaining-repeat counter.
    - If repeats remain: reload the captured pattern. The next bit is the new MSB in the very next cycle (back-to-back, no gap unless the optional feature is enabled).
    - If none remain: go to DONE.
  - DONE: one cycle. done=1, busy=1, x_valid=0, x_out=0. Next state IDLE.
- Latency and length:
  - First bit appears 1 cycle after start is accepted.
  - x_valid is high for exactly PAT_W*repeat_n consecutive cycles (no-gap build).
  - done occurs in the cycle after the last valid bit.
- start while busy or in DONE: ignored. pattern and repeat_n changes during a job have no effect; only the captured copies are used.
- start=1 held continuously: a new job is accepted on the first IDLE cycle after DONE. Minimum spacing between jobs is 1 IDLE cycle.
- x_out=0 whenever x_valid=0.
- Counters are unsigned and never wrap. The repeat counter stops at 0, and the bit counter has width clog2(PAT_W).

Optional Feature:
- Macro SEQ_GEN_GAP_EN.
- When defined:
  - One GAP state is inserted between consecutive repetitions (not after the last one).
  - In GAP: x_valid=0, x_out=0, busy=1.
  - Total job length becomes PAT_W*repeat_n + (repeat_n-1) cycles before done.
- When undefined: the GAP state and its logic are absent, and repetitions are strictly back-to-back.

Decomposition:
- Package seq_gen_pkg:
  - State encoding constants IDLE, SHIFT, GAP, DONE as 2-bit localparams.
  - Shared default PAT_W/CNT_W values.
- Sub-module seq_piso: PAT_W-bit parallel-load, MSB-first shift register with load and shift enables.
  - Instantiated once.
  - The FSM and counters stay in seq_pattern_gen.

Test Plan:
- Reset mid-job: pattern=4'b1011, repeat_n=3, assert rst on the 5th valid bit -> next cycle all outputs 0, state IDLE, no done pulse. A new start afterwards behaves normally.
- Basic: pattern=4'b1101, repeat_n=1, start pulse at edge T -> x_out=1,1,0,1 with x_valid=1 in cycles T+1..T+4; done=1 at T+5; busy low at T+6.
- Repeat no gap: pattern=4'b1101, repeat_n=2 -> 8 consecutive valid bits 1,1,0,1,1,1,0,1, done at T+9. Feeding an overlapping 1101 detector yields z=1 on bits 4 and 8.
- Zero repeat: repeat_n=0, start -> x_valid never asserted, done=1 at T+1, busy=1 only at T+1.
- Start ignored while busy: pulse start with pattern=4'b0000 during transmission -> stream unchanged. Held start produces the next job only after 1 IDLE cycle.
- Gap (SEQ_GEN_GAP_EN): pattern=4'b1101, repeat_n=2 -> bits 1,1,0,1, one cycle x_valid=0, then 1,1,0,1, done at T+10.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern generator: state encoding and
// default pattern/repeat widths.
package seq_gen_pkg;

  localparam int SEQ_GEN_PAT_W = 4;
  localparam int SEQ_GEN_CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/seq_piso.sv
// MSB-first parallel-in/serial-out shift register with load and shift enables.
// next_msb exposes the bit that will sit at the MSB after the coming edge.
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             next_msb
);

  logic [PAT_W-1:0] sreg_q;
  logic [PAT_W-1:0] sreg_d;

  // Load has priority over shift; zeros are shifted in from the LSB.
  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = din;
    end else if (shift) begin
      sreg_d = {sreg_q[PAT_W-2:0], 1'b0};
    end else begin
      sreg_d = sreg_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign next_msb = sreg_d[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB first, repeat_n times.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = SEQ_GEN_PAT_W,
  parameter int CNT_W = SEQ_GEN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = $clog2(PAT_W);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);

  state_e           state_q,   state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic             x_out_q,   x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic             piso_load_s;
  logic             piso_shift_s;
  logic [PAT_W-1:0] piso_din_s;
  logic             piso_next_msb_s;

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load_s),
    .shift    (piso_shift_s),
    .din      (piso_din_s),
    .next_msb (piso_next_msb_s)
  );

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    pat_d        = pat_q;
    piso_load_s  = 1'b0;
    piso_shift_s = 1'b0;
    piso_din_s   = pat_q;
    x_valid_d    = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          rep_cnt_d = repeat_n;
          busy_d    = 1'b1;
          if (repeat_n != '0) begin
            piso_load_s = 1'b1;
            piso_din_s  = pattern;
            bit_cnt_d   = BIT_LAST;
            x_valid_d   = 1'b1;
            state_d     = SHIFT;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (bit_cnt_q != '0) begin
          piso_shift_s = 1'b1;
          bit_cnt_d    = bit_cnt_q - BC_W'(1);
          x_valid_d    = 1'b1;
        end else begin
          // Last bit of this repetition: the repeat counter saturates at 0.
          rep_cnt_d = (rep_cnt_q != '0) ? (rep_cnt_q - CNT_W'(1)) : rep_cnt_q;
          if (rep_cnt_q > CNT_W'(1)) begin
`ifdef SEQ_GEN_GAP_EN
            state_d = GAP;
`else
            piso_load_s = 1'b1;
            bit_cnt_d   = BIT_LAST;
            x_valid_d   = 1'b1;
            state_d     = SHIFT;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        busy_d      = 1'b1;
        piso_load_s = 1'b1;
        bit_cnt_d   = BIT_LAST;
        x_valid_d   = 1'b1;
        state_d     = SHIFT;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial data is forced low whenever no pattern bit is being presented.
  always_comb begin
    x_out_d = 1'b0;
    if (x_valid_d) begin
      x_out_d = piso_next_msb_s;
    end else begin
      x_out_d = 1'b0;
    end
  end

  // State, counters, captured pattern and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      pat_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      pat_q     <= pat_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed, scoreboard-based bench for seq_pattern_gen; honours SEQ_GEN_GAP_EN.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done)
  );

  // Per-cycle expected record: {x_valid, x_out, busy, done}.
  logic [3:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [3:0]  det_hist;
  int          val_idx;
  logic [15:0] hit_mask;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_job(input logic [PAT_W-1:0] pat, input int rep);
    for (int r = 0; r < rep; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        exp_q.push_back({1'b1, pat[i], 1'b1, 1'b0});
      end
      if (GAP_EN && (r < rep - 1)) begin
        exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  // One cycle: sample on the falling edge, compare against the scoreboard,
  // and feed an overlapping 1101 detector with the valid bits.
  task automatic tick();
    logic [3:0] expv;
    logic [3:0] hist_n;
    @(negedge clk);
    cyc++;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    check($sformatf("cycle%0d", cyc), {12'h000, x_valid, x_out, busy, done}, {12'h000, expv});
    if (x_valid === 1'b1) begin
      val_idx++;
      hist_n   = {det_hist[2:0], x_out};
      det_hist = hist_n;
      if ((hist_n == 4'b1101) && (val_idx <= 16)) begin
        hit_mask[val_idx-1] = 1'b1;
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      tick();
    end
  endtask

  task automatic launch(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
    pattern  = pat;
    repeat_n = rep;
    start    = 1'b1;
    push_job(pat, int'(rep));
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    det_hist = 4'b0000;
    val_idx  = 0;
    hit_mask = 16'h0000;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic single repetition
    launch(4'b1101, 4'd1);
    drain();

    // Two repetitions feeding the 1101 detector: hits on valid bits 4 and 8
    det_hist = 4'b0000;
    val_idx  = 0;
    hit_mask = 16'h0000;
    launch(4'b1101, 4'd2);
    drain();
    check("det_hits", hit_mask, 16'h0088);

    // Zero repeat: done immediately, no valid bits
    launch(4'b1111, 4'd0);
    drain();

    // Start pulse with a different pattern while busy is ignored
    launch(4'b1011, 4'd2);
    tick();
    start    = 1'b1;
    pattern  = 4'b0000;
    repeat_n = 4'd5;
    tick();
    start    = 1'b0;
    pattern  = 4'b1111;
    drain();
    tick();

    // Held start: second job only after one IDLE cycle, using the new inputs
    pattern  = 4'b0110;
    repeat_n = 4'd1;
    start    = 1'b1;
    push_job(4'b0110, 1);
    push_job(4'b1001, 1);
    tick();
    pattern = 4'b1001;
    repeat (6) tick();
    start = 1'b0;
    drain();

    // Maximum repeat count
    launch(4'b1010, 4'd15);
    drain();

    // Reset on the 5th valid bit abandons the job without a done pulse
    launch(4'b1011, 4'd3);
    repeat (GAP_EN ? 5 : 4) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Normal job after the reset
    launch(4'b0101, 4'd2);
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
